// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data single-port RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Owner of the read whose data returns next cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } own_state_t;

  // One-hot winner of the current cycle
  typedef struct packed {
    logic d;
    logic i;
  } win_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection: a lone requester always wins; under contention prefer_i decides.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic en,
  input  logic i_req,
  input  logic d_req,
  input  logic prefer_i,
  output win_t win_c
);

  always_comb begin
    win_c = '0;
    if (en) begin
      if (i_req && (!d_req || prefer_i)) begin
        win_c.i = 1'b1;
      end else if (d_req) begin
        win_c.d = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter sharing one single-port synchronous RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating arbitration; default is data-priority with a fetch starvation guard.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  own_state_t state, next_state;
  win_t       win_c;
  logic       prefer_i;
  logic       unused_addr_lsb;

  // RAM is word addressed; byte offsets are carried by the byte enables
  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

  mem_arb_select u_select (
    .en       (~reset),
    .i_req    (i_req),
    .d_req    (d_req),
    .prefer_i (prefer_i),
    .win_c    (win_c)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_was_i;

  // Port granted last yields the next contention cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      last_was_i <= 1'b0;
    end else if (win_c.i) begin
      last_was_i <= 1'b1;
    end else if (win_c.d) begin
      last_was_i <= 1'b0;
    end
  end

  assign prefer_i = ~last_was_i;
`else
  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] starve_cnt, starve_cnt_next;

  // Saturating run length of data grants taken while fetch was waiting
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!i_req || win_c.i) begin
      starve_cnt_next = '0;
    end else if (win_c.d && (starve_cnt != CNT_W'(STARVE_MAX))) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

  assign prefer_i = (starve_cnt == CNT_W'(STARVE_MAX));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // RAM command, grants, pending-owner update and read return
  always_comb begin
    next_state = IDLE;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;

    if (win_c.i) begin
      i_gnt      = 1'b1;
      mem_en     = 1'b1;
      mem_be     = 4'hF;
      mem_addr   = i_addr[ADDR_W-1:2];
      next_state = RD_I;
    end else if (win_c.d) begin
      d_gnt      = 1'b1;
      mem_en     = 1'b1;
      mem_we     = d_we;
      mem_be     = d_be;
      mem_addr   = d_addr[ADDR_W-1:2];
      mem_wdata  = d_wdata;
      next_state = d_we ? IDLE : RD_D;
    end

    // A read still owed when reset asserts is dropped
    if (!reset) begin
      if (state == RD_I) begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
      if (state == RD_D) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a RAM model and a rule-level reference model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  logic [31:0] ram     [16];
  logic [31:0] ref_mem [16];

  int          vectors     = 0;
  int          miscompares = 0;
  int          run_len     = 0;
  bit          last_i      = 1'b0;
  int          pend        = 0;
  logic [31:0] pend_data   = 32'h0;
  bit          m_wi        = 1'b0;
  bit          m_wd        = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous RAM seen by the DUT
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[3:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict this cycle's outputs from the arbitration rules, then advance the model
  task automatic model_cycle();
    bit          wi, wd, ev_i, ev_d;
    logic [31:0] wd_word;
    wi = 1'b0;
    wd = 1'b0;
    if (!reset) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      wi = i_req && (!d_req || !last_i);
`else
      wi = i_req && (!d_req || (run_len >= int'(STARVE_MAX)));
`endif
      wd = d_req && !wi;
    end

    chk("i_gnt", 64'(i_gnt), 64'(wi));
    chk("d_gnt", 64'(d_gnt), 64'(wd));
    chk("mem_en", 64'(mem_en), 64'(wi || wd));
    if (wi) begin
      chk("mem_we_fetch", 64'(mem_we), 64'(0));
      chk("mem_be_fetch", 64'(mem_be), 64'(4'hF));
      chk("mem_addr_fetch", 64'(mem_addr), 64'(i_addr >> 2));
    end else if (wd) begin
      chk("mem_we_data", 64'(mem_we), 64'(d_we));
      chk("mem_be_data", 64'(mem_be), 64'(d_be));
      chk("mem_addr_data", 64'(mem_addr), 64'(d_addr >> 2));
      chk("mem_wdata_data", 64'(mem_wdata), 64'(d_wdata));
    end else begin
      chk("idle_cmd", {mem_we, mem_be, mem_addr, mem_wdata}, 64'(0));
    end

    ev_i = !reset && (pend == 1);
    ev_d = !reset && (pend == 2);
    chk("i_rvalid", 64'(i_rvalid), 64'(ev_i));
    chk("d_rvalid", 64'(d_rvalid), 64'(ev_d));
    chk("i_rdata", 64'(i_rdata), ev_i ? 64'(pend_data) : 64'(0));
    chk("d_rdata", 64'(d_rdata), ev_d ? 64'(pend_data) : 64'(0));

    if (reset) begin
      pend    = 0;
      run_len = 0;
      last_i  = 1'b0;
    end else begin
      pend = 0;
      if (wi) begin
        pend      = 1;
        pend_data = ref_mem[i_addr[5:2]];
        last_i    = 1'b1;
      end else if (wd) begin
        last_i = 1'b0;
        if (d_we) begin
          wd_word = ref_mem[d_addr[5:2]];
          for (int b = 0; b < 4; b++)
            if (d_be[b]) wd_word[8*b +: 8] = d_wdata[8*b +: 8];
          ref_mem[d_addr[5:2]] = wd_word;
        end else begin
          pend      = 2;
          pend_data = ref_mem[d_addr[5:2]];
        end
      end
      if (!i_req || wi) run_len = 0;
      else if (wd && run_len < int'(STARVE_MAX)) run_len++;
    end
    m_wi = wi;
    m_wd = wd;
  endtask

  task automatic tick();
    #4;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_pat;
    for (int k = 0; k < 16; k++) begin
      ram[k]     = $urandom;
      ref_mem[k] = ram[k];
    end
    reset  = 1'b1;
    i_req  = 1'b0;
    i_addr = '0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    d_be   = 4'h0;
    d_addr = '0;
    d_wdata = 32'h0;
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;

    // Single fetch read at byte 0x100
    i_req  = 1'b1;
    i_addr = 32'h100;
    tick();
    i_req = 1'b0;
    tick();
    tick();

    // Partial data write, then read it back
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h8;
    d_wdata = 32'hAABBCCDD;
    tick();
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    tick();
    d_req = 1'b1;
    tick();
    d_req = 1'b0;
    tick();

    // Continuous read contention from a fresh reset
    reset = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    d_we  = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_pat = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_pat = (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
      #3;
      chk("contention_pattern", 64'({i_gnt, d_gnt}), 64'(exp_pat));
      tick();
      if (m_wi) i_addr = 32'($urandom_range(0, 63));
      if (m_wd) d_addr = 32'($urandom_range(0, 63));
    end

    // Reset lands on the cycle after a fetch read grant
    d_req = 1'b0;
    tick();
    i_req = 1'b1;
    tick();
    reset = 1'b1;
    i_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Random traffic; requesters hold until granted
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      tick();
      if (m_wi || !i_req) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 32'($urandom_range(0, 63));
      end
      if (m_wd || !d_req) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = $urandom_range(0, 1) != 0;
        d_be    = 4'($urandom_range(0, 15));
        d_addr  = 32'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
    end
    reset = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
